char_buffer_scroll: RTL and testbench

- Parametrised text-mode character buffer. It is the successor to the fixed 7-bit x 4096 single-port character RAM.
- It has a separate write port for the keyboard/terminal side and a read port for the VGA scan side. Both ports use row/column addressing.
- It adds hardware vertical scroll through a circular top-row offset, plus a clear engine for line clear and full-screen clear.
- It sits between the terminal controller (writer) and the VGA character generator (reader).

---
 rtl/char_buffer_scroll.sv | 217 +++++++++++++++++++++
 tb/tb_char_buffer_scroll.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/char_buffer_scroll.sv
// Text-mode character buffer with row/column write and read ports, circular top-row
// hardware scroll, and a clear engine for line clear and full-screen clear.
module char_buffer_scroll #(
  parameter int unsigned         DATA_W         = 7,
  parameter int unsigned         COLS           = 80,
  parameter int unsigned         ROWS           = 50,
  parameter int unsigned         ADDR_W         = 12,
  parameter logic [DATA_W-1:0]   CLEAR_CHAR     = 7'h20,
  parameter int unsigned         READ_LAT       = 1,
  parameter bit                  CLEAR_ON_RESET = 1'b1,
  localparam int unsigned        ROW_W          = $clog2(ROWS),
  localparam int unsigned        COL_W          = $clog2(COLS)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              wr_en,
  input  logic [ROW_W-1:0]  wr_row,
  input  logic [COL_W-1:0]  wr_col,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ROW_W-1:0]  rd_row,
  input  logic [COL_W-1:0]  rd_col,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              scroll_up,
  input  logic              clear_all,
  output logic              busy,
  output logic [ROW_W-1:0]  top_row
);

  localparam int unsigned     DEPTH    = COLS * ROWS;
  localparam logic [ROW_W:0]  ROWS_EXT = (ROW_W + 1)'(ROWS);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic [ADDR_W-1:0] LAST_LINE_CNT = ADDR_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] LAST_ALL_CNT  = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StClrLine, StClrAll} state_e;

  state_e state_q, state_d;

  logic [ROW_W-1:0]  top_row_q;
  logic [ROW_W-1:0]  clr_row_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              init_pend_q;

  logic              start_all, start_line;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_accept;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic              wr_in_range, rd_in_range;

  // Initial contents only matter in simulation; hardware relies on the clear engine.
  logic [DATA_W-1:0] mem [DEPTH] = '{default: CLEAR_CHAR};

  // Logical row -> physical address through the circular top-row offset; the row sum is
  // kept one bit wider so it cannot wrap before the compare.
  function automatic logic [ADDR_W-1:0] map_addr(input logic [ROW_W-1:0] row,
                                                 input logic [COL_W-1:0] col,
                                                 input logic [ROW_W-1:0] top);
    logic [ROW_W:0] sum;
    sum = {1'b0, row} + {1'b0, top};
    if (sum >= ROWS_EXT) begin
      sum = sum - ROWS_EXT;
    end
    return ADDR_W'(sum) * ADDR_W'(COLS) + ADDR_W'(col);
  endfunction

  function automatic logic in_range(input logic [ROW_W-1:0] row,
                                    input logic [COL_W-1:0] col);
    return (32'(row) < ROWS) && (32'(col) < COLS);
  endfunction

  always_comb begin
    wr_addr     = map_addr(wr_row, wr_col, top_row_q);
    rd_addr     = map_addr(rd_row, rd_col, top_row_q);
    wr_in_range = in_range(wr_row, wr_col);
    rd_in_range = in_range(rd_row, rd_col);
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (clear_all || init_pend_q) begin
          state_d = StClrAll;
        end else if (scroll_up) begin
          state_d = StClrLine;
        end
      end
      StClrLine: begin
        if (cnt_q == LAST_LINE_CNT) begin
          state_d = StIdle;
        end
      end
      StClrAll: begin
        if (cnt_q == LAST_ALL_CNT) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs and command decode
  always_comb begin
    busy       = 1'b0;
    clr_we     = 1'b0;
    clr_addr   = cnt_q;
    start_all  = 1'b0;
    start_line = 1'b0;
    unique case (state_q)
      StIdle: begin
        start_all  = clear_all || init_pend_q;
        start_line = !start_all && scroll_up;
      end
      StClrLine: begin
        busy     = 1'b1;
        clr_we   = 1'b1;
        clr_addr = ADDR_W'(clr_row_q) * ADDR_W'(COLS) + cnt_q;
      end
      StClrAll: begin
        busy   = 1'b1;
        clr_we = 1'b1;
      end
      default: ;
    endcase
    wr_accept = resetn && !busy && wr_en && wr_in_range;
  end

  // Auto-clear request left pending by reset; consumed by the first idle cycle after release.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      init_pend_q <= CLEAR_ON_RESET;
    end else begin
      init_pend_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      top_row_q <= '0;
      clr_row_q <= '0;
      cnt_q     <= '0;
    end else if (start_all) begin
      top_row_q <= '0;
      cnt_q     <= '0;
    end else if (start_line) begin
      clr_row_q <= top_row_q;
      top_row_q <= (top_row_q == LAST_ROW) ? '0 : top_row_q + 1'b1;
      cnt_q     <= '0;
    end else if (busy) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign top_row = top_row_q;

  // Single RAM write port shared by the clear engine and the writer; they never overlap.
  always_ff @(posedge clk) begin
    if (resetn && clr_we) begin
      mem[clr_addr] <= CLEAR_CHAR;
    end else if (wr_accept) begin
      mem[wr_addr] <= wr_data;
    end
  end

  logic [DATA_W-1:0] rd1_data_q;
  logic              rd1_valid_q;

  // Read-first: the RAM read uses the value present before this edge's write.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd1_valid_q <= 1'b0;
      rd1_data_q  <= '0;
    end else begin
      rd1_valid_q <= rd_en;
      if (rd_en) begin
        rd1_data_q <= rd_in_range ? mem[rd_addr] : CLEAR_CHAR;
      end
    end
  end

  if (READ_LAT == 2) begin : g_lat2
    logic [DATA_W-1:0] rd2_data_q;
    logic              rd2_valid_q;

    always_ff @(posedge clk) begin
      if (!resetn) begin
        rd2_valid_q <= 1'b0;
        rd2_data_q  <= '0;
      end else begin
        rd2_valid_q <= rd1_valid_q;
        if (rd1_valid_q) begin
          rd2_data_q <= rd1_data_q;
        end
      end
    end

    assign rd_data  = rd2_data_q;
    assign rd_valid = rd2_valid_q;
  end else begin : g_lat1
    assign rd_data  = rd1_data_q;
    assign rd_valid = rd1_valid_q;
  end

endmodule

// File: tb/tb_char_buffer_scroll.sv
// Directed bench for char_buffer_scroll; two instances (READ_LAT 1 and 2) share all stimulus.
module tb_char_buffer_scroll;

  localparam int RW = 6;
  localparam int CW = 7;

  logic          clk = 1'b0;
  logic          resetn, wr_en, rd_en, scroll_up, clear_all;
  logic [RW-1:0] wr_row, rd_row;
  logic [CW-1:0] wr_col, rd_col;
  logic [6:0]    wr_data;
  logic [6:0]    rd_data1, rd_data2;
  logic          rd_valid1, rd_valid2, busy1, busy2;
  logic [RW-1:0] top1, top2;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  char_buffer_scroll #(.READ_LAT(1)) u_dut1 (
    .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
    .wr_data(wr_data), .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data1),
    .rd_valid(rd_valid1), .scroll_up(scroll_up), .clear_all(clear_all), .busy(busy1),
    .top_row(top1)
  );

  char_buffer_scroll #(.READ_LAT(2)) u_dut2 (
    .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
    .wr_data(wr_data), .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data2),
    .rd_valid(rd_valid2), .scroll_up(scroll_up), .clear_all(clear_all), .busy(busy2),
    .top_row(top2)
  );

  typedef struct {
    bit         wr;
    int         row;
    int         col;
    logic [6:0] data;   // write data, or expected read data
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int r, input int c, input logic [6:0] d);
    wr_en = 1'b1; wr_row = RW'(r); wr_col = CW'(c); wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  // Issues one read and checks both latencies; any wr_en set by the caller rides along.
  task automatic read_chk(input int r, input int c, input logic [6:0] exp, input string name);
    rd_en = 1'b1; rd_row = RW'(r); rd_col = CW'(c);
    step();
    rd_en = 1'b0; wr_en = 1'b0;
    chk({name, " valid lat1"}, 32'(rd_valid1), 32'd1);
    chk({name, " data lat1"}, 32'(rd_data1), 32'(exp));
    chk({name, " valid lat2 early"}, 32'(rd_valid2), 32'd0);
    step();
    chk({name, " valid lat1 drop"}, 32'(rd_valid1), 32'd0);
    chk({name, " data lat1 hold"}, 32'(rd_data1), 32'(exp));
    chk({name, " valid lat2"}, 32'(rd_valid2), 32'd1);
    chk({name, " data lat2"}, 32'(rd_data2), 32'(exp));
  endtask

  task automatic chk_state(input string name, input logic b, input int top);
    chk({name, " busy1"}, 32'(busy1), 32'(b));
    chk({name, " busy2"}, 32'(busy2), 32'(b));
    chk({name, " top1"}, 32'(top1), 32'(top));
    chk({name, " top2"}, 32'(top2), 32'(top));
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy1 && n < 10000) begin
      n++;
      step();
    end
    chk("busy2 idle", 32'(busy2), 32'd0);
  endtask

  task automatic scroll();
    scroll_up = 1'b1;
    step();
    scroll_up = 1'b0;
  endtask

  initial begin
    #5ms;
    $display("FAIL timeout: simulation still running");
    $fatal(1);
  end

  initial begin
    int n;

    // top_row is 1 when this table runs
    vecs[0]  = '{1'b1, 0, 0, 7'h31};
    vecs[1]  = '{1'b1, 50, 0, 7'h7f};   // out of range, would alias (0,0)
    vecs[2]  = '{1'b0, 0, 0, 7'h31};
    vecs[3]  = '{1'b1, 49, 79, 7'h32};  // wraps to physical row 0
    vecs[4]  = '{1'b0, 49, 79, 7'h32};
    vecs[5]  = '{1'b0, 0, 5, 7'h41};
    vecs[6]  = '{1'b0, 0, 80, 7'h20};
    vecs[7]  = '{1'b0, 50, 0, 7'h20};
    vecs[8]  = '{1'b0, 63, 127, 7'h20};
    vecs[9]  = '{1'b1, 0, 80, 7'h7e};   // out of range, would alias (1,0)
    vecs[10] = '{1'b0, 1, 0, 7'h20};
    vecs[11] = '{1'b1, 10, 40, 7'h61};
    vecs[12] = '{1'b0, 10, 40, 7'h61};
    vecs[13] = '{1'b0, 10, 41, 7'h20};

    resetn = 1'b0; wr_en = 1'b0; rd_en = 1'b0; scroll_up = 1'b0; clear_all = 1'b0;
    wr_row = '0; wr_col = '0; wr_data = '0; rd_row = '0; rd_col = '0;
    repeat (3) step();
    chk("reset rd_valid1", 32'(rd_valid1), 32'd0);
    chk("reset rd_valid2", 32'(rd_valid2), 32'd0);
    chk("reset rd_data1", 32'(rd_data1), 32'd0);
    chk("reset rd_data2", 32'(rd_data2), 32'd0);
    chk_state("reset", 1'b0, 0);

    resetn = 1'b1;
    step();
    chk_state("autoclear start", 1'b1, 0);
    wait_idle(n);
    chk("autoclear busy cycles", 32'(n), 32'd4000);
    read_chk(0, 0, 7'h20, "post-clear (0,0)");

    do_write(1, 5, 7'h41);
    scroll();
    chk_state("scroll accept", 1'b1, 1);
    wait_idle(n);
    chk("scroll busy cycles", 32'(n), 32'd80);
    read_chk(0, 5, 7'h41, "scrolled A");
    for (int c = 0; c < 80; c++) read_chk(49, c, 7'h20, $sformatf("row49 col%0d", c));

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].wr) do_write(vecs[i].row, vecs[i].col, vecs[i].data);
      else read_chk(vecs[i].row, vecs[i].col, vecs[i].data, $sformatf("vec%0d", i));
    end

    // same-cycle read and write
    do_write(2, 3, 7'h10);
    wr_en = 1'b1; wr_row = 6'd2; wr_col = 7'd3; wr_data = 7'h11;
    read_chk(2, 3, 7'h10, "read-first old");
    read_chk(2, 3, 7'h11, "read-first new");

    // write and scroll while busy are dropped
    scroll();
    wr_en = 1'b1; wr_row = 6'd3; wr_col = 7'd3; wr_data = 7'h44;
    scroll_up = 1'b1;
    step();
    wr_en = 1'b0; scroll_up = 1'b0;
    wait_idle(n);
    chk("busy-time scroll cycles", 32'(n), 32'd79);
    chk_state("busy-time scroll ignored", 1'b0, 2);
    read_chk(3, 3, 7'h20, "busy-time write dropped");

    // clear_all wins over scroll_up
    clear_all = 1'b1; scroll_up = 1'b1;
    step();
    clear_all = 1'b0; scroll_up = 1'b0;
    chk_state("clear_all+scroll", 1'b1, 0);
    wait_idle(n);
    chk("clear_all busy cycles", 32'(n), 32'd4000);
    read_chk(2, 3, 7'h20, "cleared (2,3)");

    // 50 scrolls: full wrap
    for (int i = 0; i < 50; i++) begin
      if (i == 49) begin
        do_write(0, 10, 7'h5a);   // physical row 49
        read_chk(0, 10, 7'h5a, "marker row49");
      end
      scroll();
      wait_idle(n);
      chk($sformatf("scroll%0d busy cycles", i), 32'(n), 32'd80);
      chk($sformatf("scroll%0d top", i), 32'(top1), 32'((i + 1) % 50));
    end
    read_chk(49, 10, 7'h20, "wrap cleared row49");
    read_chk(48, 10, 7'h20, "row48 clean");

    // reset at cnt=100 during CLR_ALL
    do_write(49, 79, 7'h55);
    do_write(1, 20, 7'h66);
    do_write(1, 19, 7'h67);
    clear_all = 1'b1;
    step();
    clear_all = 1'b0;
    repeat (100) step();
    resetn = 1'b0; rd_en = 1'b1; rd_row = '0; rd_col = '0;
    step();
    rd_en = 1'b0;
    chk_state("mid-clear reset", 1'b0, 0);
    chk("mid-clear rd_valid1", 32'(rd_valid1), 32'd0);
    chk("mid-clear rd_valid2", 32'(rd_valid2), 32'd0);
    resetn = 1'b1;
    read_chk(49, 79, 7'h55, "kept cell 3999");
    read_chk(1, 20, 7'h66, "kept cell 100");
    read_chk(1, 19, 7'h20, "cleared cell 99");
    wait_idle(n);
    chk("re-clear busy cycles", 32'(n), 32'd3995);
    read_chk(49, 79, 7'h20, "re-cleared 3999");
    read_chk(1, 20, 7'h20, "re-cleared 100");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
